// File: rtl/eject_scheduler.sv
// Eject scheduler: edge-detects the object sensor, timestamps rejected objects
// and fires one fixed-amplitude actuator pulse per object DELAY cycles later.
module eject_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned DELAY   = 5000,
  parameter int unsigned PULSE_W = 200,
  parameter int unsigned HOLDOFF = 50,
  parameter int unsigned AMP     = 6000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sigin,
  input  logic                     reject,
  input  logic                     enable,
  input  logic                     clr_ovf,
  output logic                     fire,
  output logic signed [14:0]       sigout,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned PEND_W = PTR_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);
  localparam int unsigned PW_W   = $clog2(PULSE_W + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] PULSE = 1'b1;

  logic              s1, s2, r1;
  logic [CNT_W-1:0]  tnow;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [0:0]        state_q, state_d;
  logic [PW_W-1:0]   wcnt_q, wcnt_d;

  logic accept_c, push_req_c, push_c, pop_c, drop_c, full_c, empty_c;

  assign full_c     = (pending == PEND_W'(DEPTH));
  assign empty_c    = (pending == '0);
  assign accept_c   = s1 & ~s2 & enable & (hold_cnt == '0);
  assign push_req_c = accept_c & r1;
  assign pop_c      = ~empty_c & (mem[rd_ptr] == tnow);
  assign push_c     = push_req_c & (~full_c | pop_c);
  assign drop_c     = push_req_c & full_c & ~pop_c;

  // Input synchronisers; reject is captured alongside the first sensor stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      r1 <= 1'b0;
    end else begin
      s1 <= sigin;
      s2 <= s1;
      r1 <= reject;
    end
  end

  // Free-running timestamp and edge holdoff counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tnow     <= '0;
      hold_cnt <= '0;
    end else begin
      tnow <= tnow + CNT_W'(1);
      if (accept_c)
        hold_cnt <= HOLD_W'(HOLDOFF);
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  // Due-time queue; a pop frees the head slot so a push while full still fits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= tnow + CNT_W'(DELAY);
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)
        pending <= pending + PEND_W'(1);
      else if (pop_c && !push_c)
        pending <= pending - PEND_W'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (drop_c)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

  // Pulse FSM next state: a due head starts or retriggers the pulse
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (pop_c) begin
          state_d = PULSE;
          wcnt_d  = PW_W'(PULSE_W);
        end
      end
      PULSE: begin
        if (pop_c)
          wcnt_d = PW_W'(PULSE_W);
        else if (wcnt_q == PW_W'(1))
          state_d = IDLE;
        else
          wcnt_d = wcnt_q - PW_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulse FSM state and registered actuator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      fire    <= 1'b0;
      sigout  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fire    <= (state_d == PULSE);
      sigout  <= (state_d == PULSE) ? 15'(AMP) : 15'd0;
    end
  end

endmodule

// File: tb/tb_eject_scheduler.sv
// Bench for eject_scheduler: directed scenarios plus randomized traffic checked
// against a model of scheduled pop edges derived from edge/holdoff/queue rules.
module tb_eject_scheduler;

  localparam int DEPTH   = 4;
  localparam int DELAY   = 20;
  localparam int PULSE_W = 5;
  localparam int HOLDOFF = 3;
  localparam int AMP     = 6000;

  logic clk = 1'b0;
  logic rst_n, sigin, reject, enable, clr_ovf;
  logic fire, overflow;
  logic signed [14:0] sigout;
  logic [2:0] pending;

  logic rst_w_n, sigin_w, reject_w, enable_w, clr_ovf_w;
  logic fire_w, overflow_w;
  logic signed [14:0] sigout_w;
  logic [2:0] pending_w;

  int errors = 0;
  int checks = 0;

  // Model state: edge index since reset and pop edges of accepted entries
  int   n;
  logic prev_sig, rise_pend, rej_pend, m_ovf;
  int   last_acc;
  int   pops[$];

  always #5 clk = ~clk;

  eject_scheduler #(.DEPTH(DEPTH), .CNT_W(14), .DELAY(DELAY), .PULSE_W(PULSE_W),
                    .HOLDOFF(HOLDOFF), .AMP(AMP)) dut (
    .clk(clk), .rst_n(rst_n), .sigin(sigin), .reject(reject), .enable(enable),
    .clr_ovf(clr_ovf), .fire(fire), .sigout(sigout), .pending(pending),
    .overflow(overflow));

  eject_scheduler #(.DEPTH(DEPTH), .CNT_W(6), .DELAY(DELAY), .PULSE_W(PULSE_W),
                    .HOLDOFF(HOLDOFF), .AMP(AMP)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .sigin(sigin_w), .reject(reject_w), .enable(enable_w),
    .clr_ovf(clr_ovf_w), .fire(fire_w), .sigout(sigout_w), .pending(pending_w),
    .overflow(overflow_w));

  function automatic logic m_fire();
    foreach (pops[i]) if (pops[i] <= n && n < pops[i] + PULSE_W) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_pend();
    int c = 0;
    foreach (pops[i]) if (pops[i] > n) c++;
    return c;
  endfunction

  function automatic logic signed [14:0] m_sig();
    return m_fire() ? 15'sd6000 : 15'sd0;
  endfunction

  task automatic model_reset();
    n = 0; prev_sig = 1'b0; rise_pend = 1'b0; rej_pend = 1'b0;
    m_ovf = 1'b0; last_acc = -100; pops.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sigin = 1'b0; reject = 1'b0; enable = 1'b1; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, settle past the edge
  task automatic step(input logic sig, input logic rej, input logic en, input logic clr);
    logic drop;
    sigin = sig; reject = rej; enable = en; clr_ovf = clr;
    @(posedge clk);
    n++;
    drop = 1'b0;
    if (rise_pend && en && (n - last_acc >= HOLDOFF + 1)) begin
      last_acc = n;
      if (rej_pend) begin
        if (m_pend() < DEPTH) pops.push_back(n + DELAY);
        else drop = 1'b1;
      end
    end
    m_ovf     = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    rise_pend = sig && !prev_sig;
    rej_pend  = rej;
    prev_sig  = sig;
    for (int i = pops.size() - 1; i >= 0; i--)
      if (pops[i] + PULSE_W <= n) pops.delete(i);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (fire !== 1'b0) begin errors++; $display("FAIL reset fire got=%b exp=0", fire); end
    checks++; if (sigout !== 15'sd0) begin errors++; $display("FAIL reset sigout got=%0d exp=0", sigout); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset pending got=%0d exp=0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single();
    logic exp_f;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      step(k == 10, 1'b1, 1'b1, 1'b0);
      exp_f = (k >= 31 && k <= 35);
      checks++; if (fire !== exp_f) begin errors++; $display("FAIL single fire n=%0d got=%b exp=%b", n, fire, exp_f); end
      checks++; if (sigout !== (exp_f ? 15'sd6000 : 15'sd0)) begin errors++; $display("FAIL single sigout n=%0d got=%0d", n, sigout); end
      checks++; if (pending !== 3'(m_pend())) begin errors++; $display("FAIL single pending n=%0d got=%0d exp=%0d", n, pending, m_pend()); end
      if (k == 11) begin
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single pend1 got=%0d exp=1", pending); end
      end
    end
  endtask

  task automatic test_no_push();
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      step(k == 10 || k == 40, k != 10, k < 35, 1'b0);
      checks++; if (fire !== 1'b0) begin errors++; $display("FAIL nopush fire n=%0d got=%b exp=0", n, fire); end
      checks++; if (pending !== 3'd0) begin errors++; $display("FAIL nopush pending n=%0d got=%0d exp=0", n, pending); end
    end
  endtask

  task automatic test_holdoff_retrigger();
    int hi, first, last;
    for (int gap = 2; gap <= 4; gap += 2) begin
      do_reset();
      hi = 0; first = -1; last = -1;
      for (int k = 1; k <= 60; k++) begin
        step(k == 10 || k == 10 + gap, 1'b1, 1'b1, 1'b0);
        checks++; if (fire !== m_fire()) begin errors++; $display("FAIL holdoff fire gap=%0d n=%0d got=%b exp=%b", gap, n, fire, m_fire()); end
        if (fire === 1'b1) begin hi++; if (first < 0) first = k; last = k; end
      end
      checks++; if (hi !== ((gap == 2) ? 5 : 9)) begin errors++; $display("FAIL holdoff width gap=%0d got=%0d exp=%0d", gap, hi, (gap == 2) ? 5 : 9); end
      checks++; if (last - first + 1 !== hi) begin errors++; $display("FAIL holdoff gapless gap=%0d span=%0d high=%0d", gap, last - first + 1, hi); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      step(k == 10 || k == 14 || k == 18 || k == 22 || k == 26, 1'b1, 1'b1, k == 55);
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf flag n=%0d got=%b exp=%b", n, overflow, m_ovf); end
      checks++; if (pending !== 3'(m_pend())) begin errors++; $display("FAIL ovf pending n=%0d got=%0d exp=%0d", n, pending, m_pend()); end
      checks++; if (fire !== m_fire()) begin errors++; $display("FAIL ovf fire n=%0d got=%b exp=%b", n, fire, m_fire()); end
      if (k == 27) begin
        checks++; if (pending !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf full pending=%0d ovf=%b exp 4/1", pending, overflow); end
      end
      if (k == 55) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf clear got=%b exp=0", overflow); end
      end
    end
  endtask

  task automatic test_wrap();
    rst_w_n = 1'b0; sigin_w = 1'b0; reject_w = 1'b1; enable_w = 1'b1; clr_ovf_w = 1'b0;
    @(negedge clk);
    rst_w_n = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      sigin_w = (k == 58);
      @(posedge clk);
      #1;
      checks++; if (fire_w !== (k >= 79 && k <= 83)) begin errors++; $display("FAIL wrap fire n=%0d got=%b", k, fire_w); end
      if (k == 59) begin
        checks++; if (pending_w !== 3'd1) begin errors++; $display("FAIL wrap pending got=%0d exp=1", pending_w); end
      end
      if (k == 79) begin
        checks++; if (sigout_w !== 15'sd6000 || pending_w !== 3'd0) begin errors++; $display("FAIL wrap pop sigout=%0d pending=%0d exp 6000/0", sigout_w, pending_w); end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    for (int k = 1; k <= 33; k++) step(k == 10 || k == 14 || k == 18, 1'b1, 1'b1, 1'b0);
    checks++; if (fire !== 1'b1 || pending !== 3'd2) begin errors++; $display("FAIL midrst pre fire=%b pending=%0d exp 1/2", fire, pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fire !== 1'b0 || sigout !== 15'sd0 || pending !== 3'd0) begin errors++; $display("FAIL midrst async fire=%b sigout=%0d pending=%0d", fire, sigout, pending); end
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (fire !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL midrst after n=%0d fire=%b pending=%0d", n, fire, pending); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 1; k <= 1500; k++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 9) != 0,
           $urandom_range(0, 19) == 0);
      checks++; if (fire !== m_fire()) begin errors++; $display("FAIL rand fire n=%0d got=%b exp=%b", n, fire, m_fire()); end
      checks++; if (sigout !== m_sig()) begin errors++; $display("FAIL rand sigout n=%0d got=%0d exp=%0d", n, sigout, m_sig()); end
      checks++; if (pending !== 3'(m_pend())) begin errors++; $display("FAIL rand pending n=%0d got=%0d exp=%0d", n, pending, m_pend()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand overflow n=%0d got=%b exp=%b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    rst_w_n = 1'b0; sigin_w = 1'b0; reject_w = 1'b0; enable_w = 1'b1; clr_ovf_w = 1'b0;
    test_reset();
    test_single();
    test_no_push();
    test_holdoff_retrigger();
    test_overflow();
    test_wrap();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
